mult_seq_param: RTL and testbench
=================================

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL support 4..32.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the signed mode; 0 forces unsigned regardless of input.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 init  input  1  start request, level-sampled in IDLE.
REQ-006 signed_mode  input  1  1 = A and B are two's complement (only when SIGNED_EN=1).
REQ-007 A  input  WIDTH  multiplicand, sampled on the accepting edge.
REQ-008 B  input  WIDTH  multiplier, sampled on the accepting edge.
REQ-009 pp  output  2*WIDTH  product register, direct register output.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-013 IDLE with init=1 at a rising edge (accepting edge) SHALL make the following updates, then go to RUN:
- load a_sh with |A|, zero-extended to 2*WIDTH;
- load b_sh with |B| (WIDTH bits);
- set neg to sign(A) XOR sign(B);
- clear pp to 0.
REQ-014 Magnitude and sign SHALL be taken only when signed_mode=1 and SIGNED_EN=1; otherwise A and B pass unchanged and neg=0.
REQ-015 |-2^(WIDTH-1)| SHALL be represented as unsigned 2^(WIDTH-1) without overflow.
REQ-016 RUN with b_sh != 0: pp += (b_sh[0] ? a_sh : 0) modulo 2^(2*WIDTH); a_sh <<= 1; b_sh >>= 1 (logical).
REQ-017 RUN with b_sh == 0: no arithmetic; go to FIX (early termination).
REQ-018 FIX: if neg=1, pp <= two's-complement negation of pp in 2*WIDTH bits, else pp is held; go to DONE.
REQ-019 DONE: done=1 for exactly this one cycle; unconditionally go to IDLE on the next edge.
REQ-020 Latency: let k = (index of the MSB of |B|) + 1, with k=0 for |B|=0; done SHALL be high in the cycle after the (k+2)th edge following the accepting edge.
REQ-021 Maximum latency SHALL be WIDTH+2 cycles after the accepting edge.
REQ-022 init SHALL be ignored in RUN, FIX and DONE; a request held high through DONE is accepted at the next IDLE edge.
REQ-023 A, B and signed_mode changes after the accepting edge SHALL NOT affect the result.
REQ-024 pp SHALL hold the final product from DONE until the next accepting edge.
REQ-025 An A=0 operand SHALL still iterate per B bits and yield pp=0 (non-negative zero, neg is ignored because -0 = 0).
REQ-026 The result SHALL be exact for all operands: signed product in range [-2^(2W-2)+2^(W-1) ... 2^(2W-2)], unsigned up to (2^W-1)^2.

Reset
REQ-027 rst=0 SHALL immediately force the following, regardless of clk: state IDLE; pp=0; a_sh=0; b_sh=0; neg=0; done=0; busy=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; the first init after rst deasserts starts a fresh operation.
REQ-029 Reset deassertion SHALL be sampled synchronously; no state change occurs on the deasserting edge unless init=1 in IDLE.

Verification (WIDTH=16, SIGNED_EN=1)
REQ-030 Unsigned, A=3, B=5, one-cycle init -> pp=0x0000000F; done pulses once in the cycle after the 5th edge following acceptance (k=3); busy high in between.
REQ-031 Signed, A=0xFFFD (-3), B=0x0007 -> pp=0xFFFFFFEB (-21); then A=0x8000, B=0x8000 -> pp=0x40000000.
REQ-032 B=0, A=0xFFFF -> pp=0; done in the cycle after the 2nd edge following acceptance.
REQ-033 Unsigned, A=0xFFFF, B=0xFFFF -> pp=0xFFFE0001; done in the cycle after the 18th edge (maximum latency); init pulses during RUN are ignored.
REQ-034 rst driven low for 3 cycles while in RUN, midway through A=0x1234, B=0x00FF -> pp, done and busy go to 0 asynchronously; a new init with A=2, B=2 yields pp=4 with no stale accumulation.
REQ-035 SIGNED_EN=0 build with signed_mode=1, A=0xFFFF, B=2 -> pp=0x0001FFFE (treated as unsigned).

Source files
------------

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, optional signed mode via magnitude/sign split.
// Latency: done pulses k+2 cycles after the accepting edge (k = MSB index of |B| + 1), max WIDTH+2.
// Backpressure: none; init is only sampled in IDLE and ignored while an operation is in flight.
module mult_seq_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] pp,
  output logic               done,
  output logic               busy
);

  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               neg;

  logic               use_sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;

  // Operand magnitudes and result sign; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    use_sign = SIGNED_EN && signed_mode;
    a_mag    = (use_sign && A[WIDTH-1]) ? ((~A) + ONE_W) : A;
    b_mag    = (use_sign && B[WIDTH-1]) ? ((~B) + ONE_W) : B;
    neg_in   = use_sign && (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and status outputs; RUN exits as soon as the multiplier is exhausted.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (init) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (b_sh == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift-add while bits remain, apply sign in FIX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pp   <= '0;
      a_sh <= '0;
      b_sh <= '0;
      neg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init) begin
            a_sh <= {{WIDTH{1'b0}}, a_mag};
            b_sh <= b_mag;
            neg  <= neg_in;
            pp   <= '0;
          end
        end
        RUN: begin
          if (b_sh != '0) begin
            if (b_sh[0]) pp <= pp + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
          end
        end
        FIX: begin
          // Negating zero yields zero, so a zero product never comes out negative.
          if (neg) pp <= (~pp) + ONE_2W;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed and random checks of mult_seq_param (WIDTH=16), signed and unsigned builds.
// Latency: expected done cycle derived per operation from the multiplier magnitude.
// Backpressure: not applicable; init pulses during RUN exercise request masking.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        init_u;
  logic        signed_mode;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] pp;
  logic [31:0] pp_u;
  logic        done;
  logic        done_u;
  logic        busy;
  logic        busy_u;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .init(init), .signed_mode(signed_mode),
    .A(A), .B(B), .pp(pp), .done(done), .busy(busy)
  );

  mult_seq_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .init(init_u), .signed_mode(signed_mode),
    .A(A), .B(B), .pp(pp_u), .done(done_u), .busy(busy_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference product computed with full-width arithmetic.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sm, input bit sen);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sp;
    if (sm && sen) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {16'h0, a} * {16'h0, b};
  endfunction

  // Expected done cycle: MSB position of |B| plus the FIX and exit cycles.
  function automatic int model_lat(input logic [15:0] b, input logic sm, input bit sen);
    logic [15:0] mag;
    int k;
    mag = (sm && sen && b[15]) ? (16'h0 - b) : b;
    k = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) k = i + 1;
    return k + 2;
  endfunction

  // One operation: accept, scramble inputs, wait for done, compare latency/product/pulse.
  task automatic run_op(input string tag, input bit sel_u, input logic [15:0] a,
                        input logic [15:0] b, input logic sm, input logic [31:0] exp_pp,
                        input int exp_lat, input bit poke_init);
    int lat;
    logic [31:0] expv;
    logic [31:0] held;
    @(negedge clk);
    A = a;
    B = b;
    signed_mode = sm;
    if (sel_u) init_u = 1'b1;
    else       init   = 1'b1;
    exp_q.push_back(exp_pp);
    @(negedge clk);
    init   = 1'b0;
    init_u = 1'b0;
    A = ~a;
    B = 16'h5A5A;
    signed_mode = ~sm;
    check({tag, " busy_after_accept"}, {31'h0, sel_u ? busy_u : busy}, 32'h1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (poke_init && c == 3) init = 1'b1;
      if (poke_init && c == 6) init = 1'b0;
      @(negedge clk);
      if (sel_u ? done_u : done) begin
        lat = c;
        break;
      end
    end
    init = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    expv = exp_q.pop_front();
    if (lat > 0) begin
      held = sel_u ? pp_u : pp;
      check({tag, " product"}, held, expv);
      check({tag, " busy_at_done"}, {31'h0, sel_u ? busy_u : busy}, 32'h0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, {31'h0, sel_u ? done_u : done}, 32'h0);
      check({tag, " product_held"}, sel_u ? pp_u : pp, expv);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    rst = 1'b0;
    init = 1'b0;
    init_u = 1'b0;
    signed_mode = 1'b0;
    A = 16'h0;
    B = 16'h0;
    repeat (2) @(negedge clk);
    check("reset pp", pp, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset pp_u", pp_u, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle after release", {31'h0, busy}, 32'h0);

    run_op("u3x5",      1'b0, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 5,  1'b0);
    run_op("s-3x7",     1'b0, 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 5,  1'b0);
    run_op("sminxmin",  1'b0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 18, 1'b0);
    run_op("b_zero",    1'b0, 16'hFFFF, 16'h0000, 1'b0, 32'h00000000, 2,  1'b0);
    run_op("umax",      1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 18, 1'b1);
    run_op("a_zero_neg",1'b0, 16'h0000, 16'hFFFB, 1'b1, 32'h00000000, 5,  1'b0);
    run_op("sminx1",    1'b0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 3,  1'b0);
    run_op("smaxxmin",  1'b0, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 18, 1'b0);

    // Abort a run with an asynchronous reset, then confirm a clean restart.
    @(negedge clk);
    A = 16'h1234;
    B = 16'h00FF;
    signed_mode = 1'b0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-run busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async rst pp", pp, 32'h0);
    check("async rst busy", {31'h0, busy}, 32'h0);
    check("async rst done", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    check("rst held done", {31'h0, done}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post rst idle", {31'h0, busy}, 32'h0);
    check("post rst pp", pp, 32'h0);
    run_op("restart2x2", 1'b0, 16'h0002, 16'h0002, 1'b0, 32'h00000004, 4, 1'b0);

    // Unsigned-only build ignores signed_mode.
    run_op("nosign", 1'b1, 16'hFFFF, 16'h0002, 1'b1, 32'h0001FFFE, 4, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op("rand_s", 1'b0, ra, rb, rs, model(ra, rb, rs, 1'b1), model_lat(rb, rs, 1'b1), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 255));
      run_op("rand_u", 1'b1, ra, rb, 1'b1, model(ra, rb, 1'b1, 1'b0), model_lat(rb, 1'b1, 1'b0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
